mem_port_arbiter: RTL and testbench

//  Shares one external memory port between the fetch unit and the load/store unit.
//  - Only one request is outstanding on the port at a time.
//  - Data requests normally win; a starvation counter guarantees fetch progress.
//  - Checks alignment and times out requests the memory never acknowledges.
//  - Sits between the core pipeline and the top-level memory pins.

---
 rtl/mem_port_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one external memory port between the fetch unit (i_*) and the
//   load/store unit (d_*). Only one transaction is outstanding on the port at
//   a time. When both units request, data is granted, but only up to MAX_DWIN
//   consecutive times while fetch waits. The next grant then goes to fetch.
//   Misaligned requests are rejected without touching the port. A port
//   transaction that gets no m_ack within TIMEOUT cycles is aborted.
//
// Ports
//   clk, rst                      clock (rising edge), synchronous active-high reset
//   i_req, i_addr                 fetch request. Held until i_ack or i_err.
//   i_rdata, i_ack, i_err         fetch response. Each pulse lasts one cycle.
//   d_req, d_we, d_size, d_addr,  data request (size 00 word, 01 half, 1x byte).
//   d_wdata                       Held until d_ack or d_err.
//   d_rdata, d_ack, d_err         data response. Load data is zero-extended.
//   m_req, m_we, m_size, m_addr,  memory port request. Registered, and held
//   m_wdata                       stable while the transaction is outstanding.
//   m_rdata, m_ack                memory port response.
module mem_port_arbiter #(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int MAX_DWIN = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ack,
  output logic          i_err,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [1:0]    d_size,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          d_err,
  output logic          m_req,
  output logic          m_we,
  output logic [1:0]    m_size,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_ack
);

  typedef enum logic [1:0] {IDLE, IBUS, DBUS, RESP} state_t;

  localparam logic [3:0] MAX_DWIN_C = 4'(MAX_DWIN);
  localparam logic [7:0] WAIT_LAST  = 8'(TIMEOUT - 1);

  state_t        state_reg;
  logic [3:0]    dwin_cnt_reg;
  logic [7:0]    wait_cnt_reg;
  logic          m_req_reg;
  logic          m_we_reg;
  logic [1:0]    m_size_reg;
  logic [AW-1:0] m_addr_reg;
  logic [DW-1:0] m_wdata_reg;
  logic [DW-1:0] i_rdata_reg;
  logic [DW-1:0] d_rdata_reg;
  logic          i_ack_reg;
  logic          i_err_reg;
  logic          d_ack_reg;
  logic          d_err_reg;

  // A requester whose ack/err is showing this cycle has just been served.
  // Its still-high request is not treated as a new request until the next cycle.
  logic i_pend;
  logic d_pend;
  logic d_wins;
  logic d_misaligned;
  logic i_misaligned;

  assign i_pend = i_req && !i_ack_reg && !i_err_reg;
  assign d_pend = d_req && !d_ack_reg && !d_err_reg;
  assign d_wins = d_pend && (!i_pend || (dwin_cnt_reg < MAX_DWIN_C));

  assign d_misaligned = ((d_size == 2'b00) && (d_addr[1:0] != 2'b00)) ||
                        ((d_size == 2'b01) && d_addr[0]);
  assign i_misaligned = (i_addr[1:0] != 2'b00);

  // Zero-extend load data according to the size of the outstanding access.
  // Bits 7:0 are always kept. Bits 15:8 are kept for half and word.
  // Everything above bit 15 is kept only for word.
  logic [DW-1:0] load_data;
  for (genvar gi = 0; gi < DW; gi++) begin : g_ext
    if (gi < 8) begin : g_byte
      assign load_data[gi] = m_rdata[gi];
    end else if (gi < 16) begin : g_half
      assign load_data[gi] = m_rdata[gi] & ~m_size_reg[1];
    end else begin : g_word
      assign load_data[gi] = m_rdata[gi] & (m_size_reg == 2'b00);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      dwin_cnt_reg <= '0;
      wait_cnt_reg <= '0;
      m_req_reg    <= 1'b0;
      m_we_reg     <= 1'b0;
      m_size_reg   <= '0;
      m_addr_reg   <= '0;
      m_wdata_reg  <= '0;
      i_rdata_reg  <= '0;
      d_rdata_reg  <= '0;
      i_ack_reg    <= 1'b0;
      i_err_reg    <= 1'b0;
      d_ack_reg    <= 1'b0;
      d_err_reg    <= 1'b0;
    end else begin
      // Response strobes are single-cycle pulses.
      i_ack_reg <= 1'b0;
      i_err_reg <= 1'b0;
      d_ack_reg <= 1'b0;
      d_err_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          wait_cnt_reg <= '0;
          if (d_wins) begin
            if (d_misaligned) begin
              d_err_reg <= 1'b1;
            end else begin
              m_req_reg   <= 1'b1;
              m_we_reg    <= d_we;
              m_size_reg  <= d_size;
              m_addr_reg  <= d_addr;
              m_wdata_reg <= d_wdata;
              state_reg   <= DBUS;
              // Count only the data grants that made a waiting fetch wait longer.
              if (i_pend) begin
                dwin_cnt_reg <= dwin_cnt_reg + 4'd1;
              end
            end
          end else if (i_pend) begin
            if (i_misaligned) begin
              i_err_reg <= 1'b1;
            end else begin
              m_req_reg    <= 1'b1;
              m_we_reg     <= 1'b0;
              m_size_reg   <= 2'b00;
              m_addr_reg   <= i_addr;
              m_wdata_reg  <= '0;
              state_reg    <= IBUS;
              dwin_cnt_reg <= '0;
            end
          end
        end
        IBUS, DBUS: begin
          if (m_ack) begin
            m_req_reg <= 1'b0;
            state_reg <= RESP;
            if (state_reg == IBUS) begin
              i_rdata_reg <= m_rdata;
              i_ack_reg   <= 1'b1;
            end else begin
              d_rdata_reg <= load_data;
              d_ack_reg   <= 1'b1;
            end
          end else if (wait_cnt_reg == WAIT_LAST) begin
            // The port cycle that just ended was the last one allowed.
            m_req_reg <= 1'b0;
            state_reg <= IDLE;
            if (state_reg == IBUS) begin
              i_err_reg <= 1'b1;
            end else begin
              d_err_reg <= 1'b1;
            end
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 8'd1;
          end
        end
        RESP: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign m_req   = m_req_reg;
  assign m_we    = m_we_reg;
  assign m_size  = m_size_reg;
  assign m_addr  = m_addr_reg;
  assign m_wdata = m_wdata_reg;
  assign i_rdata = i_rdata_reg;
  assign d_rdata = d_rdata_reg;
  assign i_ack   = i_ack_reg;
  assign i_err   = i_err_reg;
  assign d_ack   = d_ack_reg;
  assign d_err   = d_err_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed scenarios followed by randomized traffic. The bench holds a
//   reference model of the arbitration, alignment, timeout and response rules.
//   DUT outputs are compared against that model every cycle.
module tb_mem_port_arbiter;
  localparam int AW       = 32;
  localparam int DW       = 32;
  localparam int MAX_DWIN = 4;
  localparam int TIMEOUT  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_ack;
  logic          i_err;
  logic          d_req;
  logic          d_we;
  logic [1:0]    d_size;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ack;
  logic          d_err;
  logic          m_req;
  logic          m_we;
  logic [1:0]    m_size;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;
  logic          m_ack;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .AW(AW), .DW(DW), .MAX_DWIN(MAX_DWIN), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
    .m_req(m_req), .m_we(m_we), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: where the port is (0 free, 1 transaction on the port,
  // 2 response cycle), who owns it, and how many port cycles have elapsed.
  int          phase = 0;
  int          owner = 0;       // 0 fetch, 1 data
  int          port_cycles = 0;
  int          dwins = 0;       // consecutive data grants while fetch waited
  logic        e_i_ack = 0, e_i_err = 0, e_d_ack = 0, e_d_err = 0, e_mreq = 0;
  logic        e_mwe = 0;
  logic [1:0]  e_msize = 0;
  logic [31:0] e_maddr = 0, e_mwdata = 0, e_i_rdata = 0, e_d_rdata = 0;

  // Memory and requester behaviour knobs.
  int          fixed_delay = 1;  // port cycle (1-based) that gets m_ack. 0 = never. -1 = random
  int          mem_delay = 1;
  logic        use_fixed_data = 1'b1;
  logic [31:0] fixed_data = 0;
  logic        stray_en = 1'b0;
  logic        auto_req = 1'b0;
  string       grant_str = "";
  logic        last_mreq = 1'b0;

  function automatic logic misaligned(input logic [1:0] size, input logic [31:0] addr);
    if (size == 2'b00) return (addr % 4) != 0;
    if (size == 2'b01) return (addr % 2) != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] zext(input logic [1:0] size, input logic [31:0] data);
    if (size == 2'b00) return data;
    if (size == 2'b01) return data % 32'h1_0000;
    return data % 32'h100;
  endfunction

  task automatic new_i();
    i_req  = 1'b1;
    i_addr = $urandom();
    if ($urandom_range(7) != 0) i_addr[1:0] = 2'b00;
  endtask

  task automatic new_d();
    d_req   = 1'b1;
    d_we    = 1'($urandom_range(1));
    d_size  = 2'($urandom_range(3));
    d_addr  = $urandom();
    d_wdata = $urandom();
    if ($urandom_range(3) != 0) d_addr[1:0] = 2'b00;
  endtask

  task automatic pick_delay();
    if (fixed_delay >= 0) mem_delay = fixed_delay;
    else if ($urandom_range(9) == 0) mem_delay = 0;
    else mem_delay = $urandom_range(1, TIMEOUT);
  endtask

  // Advance one clock, update the model from the inputs seen at that edge,
  // compare, then drive memory and (optionally) requesters for the next cycle.
  task automatic step();
    logic pi_ack, pi_err, pd_ack, pd_err, ip, dp;
    pi_ack = e_i_ack; pi_err = e_i_err; pd_ack = e_d_ack; pd_err = e_d_err;
    @(posedge clk);
    #1;
    e_i_ack = 0; e_i_err = 0; e_d_ack = 0; e_d_err = 0;
    if (rst) begin
      phase = 0; owner = 0; port_cycles = 0; dwins = 0;
      e_mreq = 0; e_mwe = 0; e_msize = 0; e_maddr = 0; e_mwdata = 0;
      e_i_rdata = 0; e_d_rdata = 0;
    end else if (phase == 0) begin
      ip = i_req && !pi_ack && !pi_err;
      dp = d_req && !pd_ack && !pd_err;
      if (dp && (!ip || dwins < MAX_DWIN)) begin
        if (misaligned(d_size, d_addr)) e_d_err = 1;
        else begin
          phase = 1; owner = 1; port_cycles = 1; e_mreq = 1;
          e_mwe = d_we; e_msize = d_size; e_maddr = d_addr; e_mwdata = d_wdata;
          if (ip) dwins++;
          pick_delay();
        end
      end else if (ip) begin
        if (misaligned(2'b00, i_addr)) e_i_err = 1;
        else begin
          phase = 1; owner = 0; port_cycles = 1; e_mreq = 1;
          e_mwe = 0; e_msize = 2'b00; e_maddr = i_addr;
          dwins = 0;
          pick_delay();
        end
      end
    end else if (phase == 1) begin
      if (m_ack) begin
        phase = 2; e_mreq = 0;
        if (owner == 0) begin e_i_ack = 1; e_i_rdata = m_rdata; end
        else begin e_d_ack = 1; e_d_rdata = zext(e_msize, m_rdata); end
      end else if (port_cycles == TIMEOUT) begin
        phase = 0; e_mreq = 0;
        if (owner == 0) e_i_err = 1; else e_d_err = 1;
      end else begin
        port_cycles++;
      end
    end else begin
      phase = 0;
    end

    checks++;
    assert ({i_ack, i_err, d_ack, d_err, m_req} === {e_i_ack, e_i_err, e_d_ack, e_d_err, e_mreq})
      else begin errors++; $error("FAIL ctl {i_ack,i_err,d_ack,d_err,m_req} got %b want %b",
        {i_ack, i_err, d_ack, d_err, m_req}, {e_i_ack, e_i_err, e_d_ack, e_d_err, e_mreq}); end
    checks++;
    assert ({m_addr, m_we, m_size} === {e_maddr, e_mwe, e_msize})
      else begin errors++; $error("FAIL port_cmd addr/we/size got %h/%b/%b want %h/%b/%b",
        m_addr, m_we, m_size, e_maddr, e_mwe, e_msize); end
    if (owner == 1 || rst) begin
      checks++;
      assert (m_wdata === e_mwdata)
        else begin errors++; $error("FAIL m_wdata got %h want %h", m_wdata, e_mwdata); end
    end
    if (e_i_ack || rst) begin
      checks++;
      assert (i_rdata === e_i_rdata)
        else begin errors++; $error("FAIL i_rdata got %h want %h", i_rdata, e_i_rdata); end
    end
    if ((e_d_ack && !e_mwe) || rst) begin
      checks++;
      assert (d_rdata === e_d_rdata)
        else begin errors++; $error("FAIL d_rdata got %h want %h", d_rdata, e_d_rdata); end
    end

    if (m_req && !last_mreq) grant_str = {grant_str, (m_addr == d_addr) ? "D" : "I"};
    last_mreq = m_req;

    // Memory side for the cycle now starting.
    if (phase == 1) m_ack = (port_cycles == mem_delay);
    else m_ack = stray_en && ($urandom_range(7) == 0);
    m_rdata = use_fixed_data ? fixed_data : $urandom();

    // Requesters hold each request until its ack/err, then issue a new one or go quiet.
    if (auto_req) begin
      if (i_req) begin
        if (e_i_ack || e_i_err) begin
          if ($urandom_range(3) != 0) new_i(); else i_req = 0;
        end
      end else if ($urandom_range(2) == 0) new_i();
      if (d_req) begin
        if (e_d_ack || e_d_err) begin
          if ($urandom_range(3) != 0) new_d(); else d_req = 0;
        end
      end else if ($urandom_range(2) == 0) new_d();
    end
  endtask

  initial begin
    int hi;
    rst = 1; i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_size = 0; d_addr = 0;
    d_wdata = 0; m_rdata = 0; m_ack = 0;

    // Reset: every output is 0.
    step(); step();
    rst = 0;
    step();

    // 1: fetch, memory acks on the first port cycle.
    fixed_delay = 1; fixed_data = 32'h2402_0005;
    i_req = 1; i_addr = 32'h0000_0010;
    step();
    checks++;
    assert ({m_req, m_we, m_size} === 4'b1_0_00)
      else begin errors++; $error("FAIL t1_issue m_req/we/size got %b want 1000", {m_req, m_we, m_size}); end
    step();
    checks++;
    assert ({i_ack, i_rdata} === {1'b1, 32'h2402_0005})
      else begin errors++; $error("FAIL t1_ack i_ack/i_rdata got %b/%h want 1/24020005", i_ack, i_rdata); end
    $display("t1 fetch 0x10 -> i_ack=%b i_rdata=%h", i_ack, i_rdata);
    i_req = 0;
    step(); step();

    // 2: byte store.
    d_req = 1; d_we = 1; d_size = 2'b10; d_addr = 32'hF000_0000; d_wdata = 32'h41;
    step();
    checks++;
    assert ({m_req, m_we, m_size, m_wdata} === {1'b1, 1'b1, 2'b10, 32'h41})
      else begin errors++; $error("FAIL t2_issue m_req/we/size/wdata got %b/%b/%b/%h want 1/1/10/41",
        m_req, m_we, m_size, m_wdata); end
    step();
    checks++;
    assert (d_ack === 1'b1)
      else begin errors++; $error("FAIL t2_ack d_ack got %b want 1", d_ack); end
    $display("t2 store byte 0xF0000000 -> d_ack=%b", d_ack);
    d_req = 0;
    step(); step();

    // 3: both units requesting back to back.
    rst = 1; step(); rst = 0;
    grant_str = "";
    i_req = 1; i_addr = 32'h0000_0200;
    d_req = 1; d_we = 0; d_size = 2'b00; d_addr = 32'h0000_0100;
    for (int k = 0; k < 30; k++) step();
    i_req = 0; d_req = 0;
    step(); step();
    checks++;
    assert (grant_str == "DDDDIDDDDI")
      else begin errors++; $error("FAIL t3_order got %s want DDDDIDDDDI", grant_str); end
    $display("t3 grant order %s", grant_str);

    // 4: misaligned word load.
    d_req = 1; d_we = 0; d_size = 2'b00; d_addr = 32'h0800_0002;
    step();
    checks++;
    assert ({d_err, m_req} === 2'b10)
      else begin errors++; $error("FAIL t4_misalign d_err/m_req got %b want 10", {d_err, m_req}); end
    $display("t4 misaligned load -> d_err=%b m_req=%b", d_err, m_req);
    d_req = 0;
    step(); step();

    // 5: memory never answers a fetch.
    fixed_delay = 0;
    i_req = 1; i_addr = 32'h0000_0040;
    hi = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (m_req) hi++;
      if (i_err) break;
    end
    checks++;
    assert ({i_err, 8'(hi)} === {1'b1, 8'(TIMEOUT)})
      else begin errors++; $error("FAIL t5_timeout i_err/m_req_cycles got %b/%0d want 1/%0d", i_err, hi, TIMEOUT); end
    $display("t5 timeout after %0d port cycles -> i_err=%b", hi, i_err);
    i_req = 0;
    step();
    checks++;
    assert (m_req === 1'b0)
      else begin errors++; $error("FAIL t5_idle m_req got %b want 0", m_req); end

    // 6: reset in the middle of a data transaction.
    d_req = 1; d_we = 0; d_size = 2'b00; d_addr = 32'h0000_0300;
    step(); step(); step();
    rst = 1;
    step();
    checks++;
    assert ({m_req, d_ack, d_err, m_addr} === {3'b000, 32'h0})
      else begin errors++; $error("FAIL t6_reset m_req/d_ack/d_err/m_addr got %b/%b/%b/%h want 0/0/0/0",
        m_req, d_ack, d_err, m_addr); end
    $display("t6 reset mid-DBUS -> m_req=%b d_ack=%b d_err=%b", m_req, d_ack, d_err);
    rst = 0; d_req = 0;
    step(); step();

    // Randomized traffic with stray acks, random latencies and timeouts.
    fixed_delay = -1; use_fixed_data = 0; stray_en = 1; auto_req = 1;
    for (int k = 0; k < 3000; k++) step();
    auto_req = 0; i_req = 0; d_req = 0;
    for (int k = 0; k < 20; k++) step();
    $display("random phase done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
